pulse_param_ctrl: RTL and testbench
===================================

# pulse_param_ctrl

Parametrised UART-side command engine for the pulse generator. It assembles fixed-length frames from a byte stream: `PAYLOAD_BYTES` data bytes, LSB first, followed by one command byte. It writes or reads back one of `NUM_REGS` pulse-parameter registers and returns a checksum or readback response over a byte-wide transmit handshake. It sits between the UART core and the pulse timing logic and succeeds the fixed 4-byte, 10-command controller with a generic register file, an inter-byte timeout and optional readback.

## Interface
- `PAYLOAD_BYTES`, default 4: data bytes per frame, range 1..8.
- `NUM_REGS`, default 16: number of parameter registers, range 1..128.
- `REG_W`, default 32: register width, range 1..8*`PAYLOAD_BYTES`.
- `RESET_VALS`, default 0: flat `NUM_REGS*REG_W` vector; register i resets to slice i.
- `TIMEOUT_CYC`, default 2_000_000: maximum clk cycles between bytes of one frame.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_valid` in 1: UART "received" flag. It may be a pulse or a level; the block acts only on its rising edge.
- `rx_byte` in 8: received byte, valid while `rx_valid` is high.
- `tx_busy` in 1: UART is transmitting.
- `tx_start` out 1: one-cycle transmit request.
- `tx_byte` out 8: byte to transmit, held stable from `tx_start` until the next `tx_start`.
- `regs_flat` out `NUM_REGS*REG_W`: all registers; register i is at `[i*REG_W +: REG_W]`.
- `upd_strobe` out 1: one-cycle pulse when a register is written.
- `upd_addr` out 7: address of the last write.
- `rx_done` out 1: high from EXEC until the last response byte has been handed off.
- `frame_err` out 1: one-cycle pulse on timeout or invalid command.

## Operation
- An `rx_valid` rising edge is detected with a 1-flop delayed copy of `rx_valid`. `rx_byte` is sampled in the edge cycle.
- States:
  - **RECV**: byte k (0..`PAYLOAD_BYTES`-1) goes to `payload[8k +: 8]`. The byte at k=`PAYLOAD_BYTES` is the command; the byte counter clears and the state goes to EXEC.
  - **EXEC**: decodes the command, updates registers, loads the response and goes to TX_LOAD.
  - **TX_LOAD**: waits for `tx_busy`=0, then pulses `tx_start` and goes to TX_WAIT.
  - **TX_WAIT**: ignores `tx_busy` in the first cycle, then waits for `tx_busy`=0. If more response bytes remain it goes to TX_LOAD, otherwise to RECV.
- Command byte: bit7 = read flag; bits[6:0] = address.
- Checksum: 8-bit sum, modulo 256, of all payload bytes.
- Write (bit7=0, address<`NUM_REGS`):
  - `reg[address]` <= `payload[REG_W-1:0]`.
  - `upd_strobe`=1 and `upd_addr`=address.
  - Response is 1 byte: the checksum.
- Read (bit7=1, address<`NUM_REGS`):
  - No register is modified.
  - Response is `PAYLOAD_BYTES` bytes of `reg[address]`, zero-extended, LSB first, then the checksum byte.
- Invalid (address>=`NUM_REGS`, or read with readback compiled out):
  - No write.
  - `frame_err` pulses.
  - Response is 1 byte: the bitwise inverse of the checksum.
- Timeout: in RECV with the byte counter >0, an idle counter increments every cycle and clears on each rx edge. On reaching `TIMEOUT_CYC`, the partial frame is discarded, the counter clears and `frame_err` pulses. The state stays RECV.
- Rx edges arriving in EXEC, TX_LOAD or TX_WAIT are dropped and do not count toward the next frame.
- Reset values: registers = `RESET_VALS`, state = RECV, counters = 0, `tx_start`=0, `tx_byte`=0, `upd_strobe`=0, `upd_addr`=0, `rx_done`=0, `frame_err`=0. Asserting `rst_n` mid-frame or mid-transmit aborts immediately; no partial write ever lands.

## Timing
- Command byte edge at cycle N:
  - EXEC at N+1.
  - `regs_flat` updated and `upd_strobe` high at N+2.
  - Earliest `tx_start` at N+2 if `tx_busy`=0.
- `rx_done` rises at N+1 and falls in the cycle after the final TX_WAIT completes.
- Minimum of 2 cycles between consecutive `tx_start` pulses.
- A timeout and an rx edge in the same cycle: the byte wins and the timer clears.

## Configuration
- `PULSE_CTRL_READBACK_EN`:
  - Defined: read commands return the register contents as described.
  - Undefined: the readback mux and multi-byte response logic are not built. Every command with bit7=1 is treated as invalid: `frame_err` pulses and the response is the single inverted-checksum byte.

## Test plan
- Defaults: `PAYLOAD_BYTES`=4, `NUM_REGS`=16.
- Write test: frame 0xC8,0x00,0x00,0x00,0x00 -> `reg[0]`=0x000000C8, `upd_strobe` pulses once with `upd_addr`=0, single tx byte 0xC8.
- Readback test (`PULSE_CTRL_READBACK_EN` defined): write 0x12345678 to reg 5, then frame 0,0,0,0,0x85 -> tx bytes 0x78,0x56,0x34,0x12,0x00.
- Invalid address test: frame 1,2,3,4,0x20 -> no register change, `frame_err` pulses, tx byte 0xF5.
- Timeout test: send 2 bytes, idle `TIMEOUT_CYC` cycles -> `frame_err`; next full frame 0x10,0,0,0,0x03 writes `reg[3]`=0x10.
- Level `rx_valid` test: hold `rx_valid` high for 50 cycles per byte -> each byte counted once. Edges during TX are dropped.
- Reset test: assert `rst_n`=0 after 3 payload bytes and again while `tx_busy`=1 -> all registers equal `RESET_VALS` and no `tx_start` follows.

Source files
------------

// File: rtl/pulse_param_ctrl.sv
// UART-side frame engine: PAYLOAD_BYTES data bytes + command byte -> register write/readback with response.
// Optional readback path enabled by defining PULSE_CTRL_READBACK_EN.
module pulse_param_ctrl #(
  parameter int unsigned                 PAYLOAD_BYTES = 4,
  parameter int unsigned                 NUM_REGS      = 16,
  parameter int unsigned                 REG_W         = 32,
  parameter logic [NUM_REGS*REG_W-1:0]   RESET_VALS    = '0,
  parameter int unsigned                 TIMEOUT_CYC   = 2_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_byte,
  input  logic                      tx_busy,
  output logic                      tx_start,
  output logic [7:0]                tx_byte,
  output logic [NUM_REGS*REG_W-1:0] regs_flat,
  output logic                      upd_strobe,
  output logic [6:0]                upd_addr,
  output logic                      rx_done,
  output logic                      frame_err
);

  localparam int unsigned PW = 8 * PAYLOAD_BYTES;

  typedef enum logic [1:0] {RECV, EXEC, TX_LOAD, TX_WAIT} state_t;

  state_t           state, state_nxt;
  logic             rx_prev;
  logic             rx_edge;
  logic [3:0]       byte_cnt;
  logic [31:0]      idle_cnt;
  logic [PW-1:0]    payload;
  logic [7:0]       cmd;
  logic [REG_W-1:0] regs [NUM_REGS];
  logic             wait_first;
  logic [7:0]       chk;
  logic             is_read;
  logic             addr_ok;
  logic             cmd_bad;
  logic             wr_en;
  logic             wait_done;
  logic             resp_more;

  assign rx_edge = rx_valid & ~rx_prev;

  always_comb begin
    chk = '0;
    for (int unsigned k = 0; k < PAYLOAD_BYTES; k++)
      chk = chk + payload[8*k +: 8];
  end

  assign is_read = cmd[7];
  assign addr_ok = 32'(cmd[6:0]) < NUM_REGS;
`ifdef PULSE_CTRL_READBACK_EN
  assign cmd_bad = ~addr_ok;
`else
  assign cmd_bad = ~addr_ok | is_read;
`endif
  assign wr_en     = (state == EXEC) && !is_read && addr_ok;
  assign wait_done = (state == TX_WAIT) && !wait_first && !tx_busy;

`ifdef PULSE_CTRL_READBACK_EN
  logic [PW-1:0] rdata;
  logic [PW-1:0] resp_sh;
  logic [3:0]    resp_left;

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (cmd[6:0] == 7'(i)) rdata[REG_W-1:0] = regs[i];
  end

  assign resp_more = (resp_left != '0);
`else
  assign resp_more = 1'b0;
`endif

  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      regs_flat[i*REG_W +: REG_W] = regs[i];
  end

  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    case (state)
      RECV:    if (rx_edge && byte_cnt == 4'(PAYLOAD_BYTES)) state_nxt = EXEC;
      EXEC:    state_nxt = TX_LOAD;
      TX_LOAD: if (!tx_busy) begin
                 tx_start  = 1'b1;
                 state_nxt = TX_WAIT;
               end
      TX_WAIT: if (wait_done) state_nxt = resp_more ? TX_LOAD : RECV;
      default: state_nxt = RECV;
    endcase
  end

  assign rx_done = (state != RECV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RECV;
      rx_prev    <= 1'b0;
      byte_cnt   <= '0;
      idle_cnt   <= '0;
      payload    <= '0;
      cmd        <= '0;
      wait_first <= 1'b0;
      tx_byte    <= '0;
      upd_strobe <= 1'b0;
      upd_addr   <= '0;
      frame_err  <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++)
        regs[i] <= RESET_VALS[i*REG_W +: REG_W];
`ifdef PULSE_CTRL_READBACK_EN
      resp_sh    <= '0;
      resp_left  <= '0;
`endif
    end else begin
      state      <= state_nxt;
      rx_prev    <= rx_valid;
      upd_strobe <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RECV: begin
          // an rx edge takes priority over a timeout in the same cycle
          if (rx_edge) begin
            idle_cnt <= '0;
            if (byte_cnt == 4'(PAYLOAD_BYTES)) begin
              cmd      <= rx_byte;
              byte_cnt <= '0;
            end else begin
              for (int unsigned k = 0; k < PAYLOAD_BYTES; k++)
                if (byte_cnt == 4'(k)) payload[8*k +: 8] <= rx_byte;
              byte_cnt <= byte_cnt + 4'd1;
            end
          end else if (byte_cnt != '0) begin
            if (idle_cnt == 32'(TIMEOUT_CYC - 1)) begin
              idle_cnt  <= '0;
              byte_cnt  <= '0;
              frame_err <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 32'd1;
            end
          end else begin
            idle_cnt <= '0;
          end
        end
        EXEC: begin
          if (wr_en) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
              if (cmd[6:0] == 7'(i)) regs[i] <= payload[REG_W-1:0];
            upd_strobe <= 1'b1;
            upd_addr   <= cmd[6:0];
          end
          if (cmd_bad) begin
            frame_err <= 1'b1;
            tx_byte   <= ~chk;
          end
`ifdef PULSE_CTRL_READBACK_EN
          else if (is_read) begin
            // first byte goes out now; the rest (upper bytes, then checksum) queue in resp_sh
            tx_byte   <= rdata[7:0];
            resp_sh   <= PW'({chk, rdata} >> 8);
            resp_left <= 4'(PAYLOAD_BYTES);
          end
`endif
          else begin
            tx_byte <= chk;
          end
        end
        TX_LOAD: wait_first <= 1'b1;
        TX_WAIT: begin
          wait_first <= 1'b0;
`ifdef PULSE_CTRL_READBACK_EN
          if (wait_done && resp_more) begin
            tx_byte   <= resp_sh[7:0];
            resp_sh   <= resp_sh >> 8;
            resp_left <= resp_left - 4'd1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_param_ctrl.sv
// Directed bench for pulse_param_ctrl: write, readback, invalid, timeout, level rx_valid, reset abort.
module tb_pulse_param_ctrl;

  localparam int unsigned NR   = 16;
  localparam int unsigned RW   = 32;
  localparam int unsigned TOC  = 100;
  localparam int          BUSY_LEN = 5;
  localparam logic [NR*RW-1:0] RV = {{(NR-2)*RW{1'b0}}, 32'hDEADBEEF, 32'h0};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rx_valid = 1'b0;
  logic [7:0]       rx_byte = '0;
  logic             tx_busy;
  logic             tx_start;
  logic [7:0]       tx_byte;
  logic [NR*RW-1:0] regs_flat;
  logic             upd_strobe;
  logic [6:0]       upd_addr;
  logic             rx_done;
  logic             frame_err;

  logic             busy_hold = 1'b0;
  logic             busy_model = 1'b0;
  int               busy_cnt = 0;
  int               upd_cnt = 0;
  int               err_cnt = 0;
  logic [7:0]       txq[$];
  logic [RW-1:0]    exp_regs [NR];
  int               n_cmp = 0;
  int               n_err = 0;

  pulse_param_ctrl #(
    .PAYLOAD_BYTES(4),
    .NUM_REGS(NR),
    .REG_W(RW),
    .RESET_VALS(RV),
    .TIMEOUT_CYC(TOC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_byte(tx_byte),
    .regs_flat(regs_flat), .upd_strobe(upd_strobe), .upd_addr(upd_addr),
    .rx_done(rx_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  assign tx_busy = busy_hold | busy_model;

  // UART stand-in: each tx_start keeps tx_busy high for BUSY_LEN cycles
  always @(negedge clk) begin
    if (tx_start) begin
      txq.push_back(tx_byte);
      busy_cnt = BUSY_LEN;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    busy_model = (busy_cnt > 0);
    if (upd_strobe) upd_cnt++;
    if (frame_err)  err_cnt++;
  end

  function automatic logic [NR*RW-1:0] exp_flat();
    logic [NR*RW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*RW +: RW] = exp_regs[i];
    return f;
  endfunction

  function automatic bit q_eq(input logic [7:0] a[$], input logic [7:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    for (int i = 0; i < a.size(); i++) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) exp_regs[i] = RV[i*RW +: RW];
  endtask

  task automatic clear_mon();
    @(negedge clk);
    txq.delete();
    upd_cnt = 0;
    err_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    repeat (hold) @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                            input logic [7:0] p3, input logic [7:0] c, input int hold);
    send_byte(p0, hold); send_byte(p1, hold); send_byte(p2, hold); send_byte(p3, hold);
    send_byte(c, hold);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (!rx_done && !busy_model && !tx_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (regs_flat !== exp_flat()) begin
      n_err++; $display("FAIL reset_regs: got %h want %h", regs_flat, exp_flat());
    end
    n_cmp++;
    if ({tx_start, tx_byte, upd_strobe, upd_addr, rx_done, frame_err} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_outs: got start=%b byte=%h upd=%b addr=%h done=%b err=%b want all 0",
               tx_start, tx_byte, upd_strobe, upd_addr, rx_done, frame_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    bit ok;
    clear_mon();
    send_byte(8'hC8, 1); send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
    @(negedge clk);
    rx_byte = 8'h00; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    n_cmp++;
    if (rx_done !== 1'b1 || upd_strobe !== 1'b0) begin
      n_err++; $display("FAIL wr_exec_cycle: got done=%b upd=%b want 1 0", rx_done, upd_strobe);
    end
    @(negedge clk);
    n_cmp++;
    if (upd_strobe !== 1'b1 || tx_start !== 1'b1 || tx_byte !== 8'hC8 || regs_flat[31:0] !== 32'hC8) begin
      n_err++;
      $display("FAIL wr_n2_timing: got upd=%b start=%b byte=%h reg0=%h want 1 1 c8 000000c8",
               upd_strobe, tx_start, tx_byte, regs_flat[31:0]);
    end
    exp_regs[0] = 32'h0000_00C8;
    wait_idle(ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL wr_idle: got timeout want idle"); end
    n_cmp++;
    if (!q_eq(txq, '{8'hC8})) begin n_err++; $display("FAIL wr_tx: got %p want '{c8}", txq); end
    n_cmp++;
    if (upd_cnt !== 1 || upd_addr !== 7'd0 || err_cnt !== 0) begin
      n_err++; $display("FAIL wr_upd: got cnt=%0d addr=%0d err=%0d want 1 0 0", upd_cnt, upd_addr, err_cnt);
    end
    n_cmp++;
    if (regs_flat !== exp_flat()) begin
      n_err++; $display("FAIL wr_regs: got %h want %h", regs_flat, exp_flat());
    end
  endtask

  task automatic test_readback();
    bit ok;
    clear_mon();
    send_frame(8'h78, 8'h56, 8'h34, 8'h12, 8'h05, 1);
    wait_idle(ok);
    exp_regs[5] = 32'h1234_5678;
    n_cmp++;
    if (!ok || !q_eq(txq, '{8'h14}) || upd_addr !== 7'd5) begin
      n_err++; $display("FAIL rb_write: got ok=%b tx=%p addr=%0d want 1 '{14} 5", ok, txq, upd_addr);
    end
    clear_mon();
    send_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h85, 1);
    wait_idle(ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL rb_idle: got timeout want idle"); end
`ifdef PULSE_CTRL_READBACK_EN
    n_cmp++;
    if (!q_eq(txq, '{8'h78, 8'h56, 8'h34, 8'h12, 8'h00})) begin
      n_err++; $display("FAIL rb_tx: got %p want '{78,56,34,12,00}", txq);
    end
    n_cmp++;
    if (err_cnt !== 0 || upd_cnt !== 0) begin
      n_err++; $display("FAIL rb_flags: got err=%0d upd=%0d want 0 0", err_cnt, upd_cnt);
    end
`else
    n_cmp++;
    if (!q_eq(txq, '{8'hFF})) begin n_err++; $display("FAIL rb_off_tx: got %p want '{ff}", txq); end
    n_cmp++;
    if (err_cnt !== 1 || upd_cnt !== 0) begin
      n_err++; $display("FAIL rb_off_flags: got err=%0d upd=%0d want 1 0", err_cnt, upd_cnt);
    end
`endif
    n_cmp++;
    if (regs_flat !== exp_flat()) begin
      n_err++; $display("FAIL rb_regs: got %h want %h", regs_flat, exp_flat());
    end
  endtask

  task automatic test_invalid();
    bit ok;
    clear_mon();
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h20, 1);
    wait_idle(ok);
    n_cmp++;
    if (!ok || !q_eq(txq, '{8'hF5})) begin
      n_err++; $display("FAIL inv_tx: got ok=%b tx=%p want 1 '{f5}", ok, txq);
    end
    n_cmp++;
    if (err_cnt !== 1 || upd_cnt !== 0) begin
      n_err++; $display("FAIL inv_flags: got err=%0d upd=%0d want 1 0", err_cnt, upd_cnt);
    end
    n_cmp++;
    if (regs_flat !== exp_flat()) begin
      n_err++; $display("FAIL inv_regs: got %h want %h", regs_flat, exp_flat());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int seen;
    clear_mon();
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 1);
    // last edge is 3 cycles back; frame_err is registered 100 cycles after it
    seen = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (frame_err) begin seen = c; break; end
    end
    n_cmp++;
    if (seen < 97 || seen > 99) begin
      n_err++; $display("FAIL to_fire: got cycle %0d want 97..99", seen);
    end
    send_frame(8'h10, 8'h00, 8'h00, 8'h00, 8'h03, 1);
    wait_idle(ok);
    exp_regs[3] = 32'h10;
    n_cmp++;
    if (!ok || !q_eq(txq, '{8'h10}) || err_cnt !== 1 || upd_addr !== 7'd3) begin
      n_err++; $display("FAIL to_next: got ok=%b tx=%p err=%0d addr=%0d want 1 '{10} 1 3",
                        ok, txq, err_cnt, upd_addr);
    end
    n_cmp++;
    if (regs_flat !== exp_flat()) begin
      n_err++; $display("FAIL to_regs: got %h want %h", regs_flat, exp_flat());
    end
  endtask

  task automatic test_level_rx();
    bit ok;
    clear_mon();
    send_frame(8'hA5, 8'h5A, 8'h00, 8'h00, 8'h07, 50);
    wait_idle(ok);
    exp_regs[7] = 32'h5AA5;
    n_cmp++;
    if (!ok || !q_eq(txq, '{8'hFF}) || upd_cnt !== 1 || err_cnt !== 0) begin
      n_err++; $display("FAIL lvl_frame: got ok=%b tx=%p upd=%0d err=%0d want 1 '{ff} 1 0",
                        ok, txq, upd_cnt, err_cnt);
    end
    n_cmp++;
    if (regs_flat !== exp_flat()) begin
      n_err++; $display("FAIL lvl_regs: got %h want %h", regs_flat, exp_flat());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_mon();
    send_frame(8'h01, 8'h00, 8'h00, 8'h00, 8'h08, 1);
    send_byte(8'h77, 1);
    wait_idle(ok);
    send_frame(8'h02, 8'h00, 8'h00, 8'h00, 8'h09, 1);
    wait_idle(ok);
    exp_regs[8] = 32'h1;
    exp_regs[9] = 32'h2;
    n_cmp++;
    if (!ok || !q_eq(txq, '{8'h01, 8'h02}) || upd_cnt !== 2 || err_cnt !== 0) begin
      n_err++; $display("FAIL b2b_tx: got ok=%b tx=%p upd=%0d err=%0d want 1 '{01,02} 2 0",
                        ok, txq, upd_cnt, err_cnt);
    end
    n_cmp++;
    if (regs_flat !== exp_flat()) begin
      n_err++; $display("FAIL b2b_regs: got %h want %h", regs_flat, exp_flat());
    end
  endtask

  task automatic test_reset_abort();
    clear_mon();
    send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1);
    do_reset();
    model_reset();
    send_byte(8'h44, 1);
    send_byte(8'h04, 1);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (txq.size() != 0 || upd_cnt !== 0 || regs_flat !== exp_flat()) begin
      n_err++; $display("FAIL rst_midframe: got tx=%p upd=%0d regs=%h want '{} 0 %h",
                        txq, upd_cnt, regs_flat, exp_flat());
    end
    do_reset();
    clear_mon();
    busy_hold = 1'b1;
    send_frame(8'h55, 8'h00, 8'h00, 8'h00, 8'h06, 1);
    repeat (3) @(negedge clk);
    do_reset();
    busy_hold = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (txq.size() != 0 || rx_done !== 1'b0 || regs_flat !== exp_flat()) begin
      n_err++; $display("FAIL rst_midtx: got tx=%p done=%b regs=%h want '{} 0 %h",
                        txq, rx_done, regs_flat, exp_flat());
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_readback();
    test_invalid();
    test_timeout();
    test_level_rx();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
